// File: rtl/axis_frame_arb_mux.sv
// axis_frame_arb_mux
//
// Merges PORTS AXI-stream-style inputs onto a single output stream. Arbitration
// is per frame: once a port is granted it keeps the grant until its tlast beat
// is accepted, so frames are never interleaved. There is no preemption.
// Arbitration is fixed priority or round robin. The output is registered and
// backed by a one-beat skid register, so upstream ready is never combinationally
// dependent on m_tready.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   s_tdata      PORTS*DATA_WIDTH input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid     per-port valid
//   s_tlast      per-port end of frame
//   s_tready     per-port ready (only the granted port can be ready)
//   m_tdata      output data
//   m_tvalid     output valid
//   m_tlast      output end of frame
//   m_tid        source port index of the current output beat
//   m_tready     downstream ready
//   busy         a frame is currently granted
//
// Parameters:
//   TYPE          "PRIORITY" or "ROUND_ROBIN"
//   LSB_PRIORITY  "HIGH": port 0 has the highest priority;
//                 "LOW":  the highest index has the highest priority

module axis_frame_arb_mux #(
  parameter int unsigned PORTS        = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter string       TYPE         = "ROUND_ROBIN",
  parameter string       LSB_PRIORITY = "LOW",
  localparam int unsigned IdW         = $clog2(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [PORTS-1:0]              s_tvalid,
  input  logic [PORTS-1:0]              s_tlast,
  output logic [PORTS-1:0]              s_tready,

  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic [IdW-1:0]                m_tid,
  input  logic                          m_tready,

  output logic                          busy
);

  localparam bit RoundRobin = (TYPE == "ROUND_ROBIN");
  localparam bit Port0First = (LSB_PRIORITY == "HIGH");

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Arbiter / grant state
  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_oh_q, grant_oh_d;
  logic [IdW-1:0]   grant_idx_q, grant_idx_d;
  logic             busy_q, busy_d;
  logic [PORTS-1:0] mask_q, mask_d;

  // Output register
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [IdW-1:0]        out_id_q, out_id_d;

  // Skid register
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [IdW-1:0]        skid_id_q, skid_id_d;

  logic [PORTS-1:0]      req_masked;
  logic [IdW-1:0]        win_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  // Highest-priority set bit of req. Scans from lowest to highest priority so
  // the final hit is the winner.
  function automatic logic [IdW-1:0] pick_winner(input logic [PORTS-1:0] req);
    logic [IdW-1:0] idx;
    idx = '0;
    if (Port0First) begin
      for (int i = int'(PORTS) - 1; i >= 0; i--) begin
        if (req[i]) idx = IdW'(i);
      end
    end else begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (req[i]) idx = IdW'(i);
      end
    end
    return idx;
  endfunction

  // Ports strictly lower in priority than k.
  function automatic logic [PORTS-1:0] lower_prio_mask(input logic [IdW-1:0] k);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      m[i] = Port0First ? (i > int'(k)) : (i < int'(k));
    end
    return m;
  endfunction

  // Arbitration: masked requests first; fall back to all requests when the
  // masked set is empty (wrap-around of the round robin).
  always_comb begin
    req_masked = s_tvalid & mask_q;
    if (RoundRobin && (|req_masked)) begin
      win_idx = pick_winner(req_masked);
    end else begin
      win_idx = pick_winner(s_tvalid);
    end
  end

  // Granted-port input mux, driven from the one-hot grant.
  always_comb begin
    in_data = '0;
    in_last = 1'b0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (grant_oh_q[i]) begin
        in_data = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_last = s_tlast[i];
      end
    end
  end

  // Ready only to the granted port, and only while the skid slot is free.
  always_comb begin
    s_tready = '0;
    if (state_q == StActive && !skid_valid_q) begin
      s_tready = grant_oh_q;
    end
  end

  assign accept = |(s_tvalid & s_tready);

  // Grant FSM
  always_comb begin
    state_d     = state_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    mask_d      = mask_q;
    unique case (state_q)
      StIdle: begin
        if (|s_tvalid) begin
          state_d              = StActive;
          grant_idx_d          = win_idx;
          grant_oh_d           = '0;
          grant_oh_d[win_idx]  = 1'b1;
          busy_d               = 1'b1;
          if (RoundRobin) begin
            mask_d = lower_prio_mask(win_idx);
          end
        end
      end
      StActive: begin
        // Leaving on the tlast accept forces one idle arbitration cycle
        // between frames.
        if (accept && in_last) begin
          state_d    = StIdle;
          grant_oh_d = '0;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        grant_oh_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Output register + skid register
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_id_d     = out_id_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_id_d    = skid_id_q;

    if (!out_valid_q || m_tready) begin
      // Output slot free or draining this cycle.
      if (skid_valid_q) begin
        // No accept can happen while the skid is full, so nothing is lost.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_id_d     = skid_id_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_last_d  = in_last;
        out_id_d    = grant_idx_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the beat in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_last_d  = in_last;
      skid_id_d    = grant_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_oh_q   <= '0;
      grant_idx_q  <= '0;
      busy_q       <= 1'b0;
      mask_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_id_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_oh_q   <= grant_oh_d;
      grant_idx_q  <= grant_idx_d;
      busy_q       <= busy_d;
      mask_q       <= mask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_id_q     <= out_id_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_id_q    <= skid_id_d;
    end
  end

  assign m_tvalid = out_valid_q;
  assign m_tdata  = out_data_q;
  assign m_tlast  = out_last_q;
  assign m_tid    = out_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Directed bench for axis_frame_arb_mux. Four instances cover the arbitration
// flavours, each with its own stimulus:
//   0: PRIORITY / HIGH   1: PRIORITY / LOW   2: ROUND_ROBIN / LOW   3: ROUND_ROBIN / HIGH
module tb_axis_frame_arb_mux;

  localparam int NumDut = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [31:0] s_tdata  [NumDut];
  logic [3:0]  s_tvalid [NumDut];
  logic [3:0]  s_tlast  [NumDut];
  logic [3:0]  s_tready [NumDut];
  logic [7:0]  m_tdata  [NumDut];
  logic        m_tvalid [NumDut];
  logic        m_tlast  [NumDut];
  logic [1:0]  m_tid    [NumDut];
  logic        m_tready [NumDut];
  logic        busy     [NumDut];

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    axis_frame_arb_mux #(
      .PORTS        (4),
      .DATA_WIDTH   (8),
      .TYPE         ((g < 2) ? "PRIORITY" : "ROUND_ROBIN"),
      .LSB_PRIORITY ((g == 0 || g == 3) ? "HIGH" : "LOW")
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_tdata  (s_tdata[g]),
      .s_tvalid (s_tvalid[g]),
      .s_tlast  (s_tlast[g]),
      .s_tready (s_tready[g]),
      .m_tdata  (m_tdata[g]),
      .m_tvalid (m_tvalid[g]),
      .m_tlast  (m_tlast[g]),
      .m_tid    (m_tid[g]),
      .m_tready (m_tready[g]),
      .busy     (busy[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  d;
    logic [31:0] cyc;
    logic [7:0]  data;
    logic [1:0]  id;
    logic        last;
  } beat_t;

  beat_t mon_q[$];
  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Log every output handshake; sampled at negedge, completes at next posedge.
  always @(negedge clk) begin
    for (int k = 0; k < NumDut; k++) begin
      if (rst_n && m_tvalid[k] && m_tready[k]) begin
        mon_q.push_back('{d: 2'(k), cyc: 32'(cyc), data: m_tdata[k], id: m_tid[k],
                          last: m_tlast[k]});
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_beat(input int d, input logic [7:0] data, input int id, input logic last);
    exp_q.push_back('{d: 2'(d), cyc: 32'd0, data: data, id: 2'(id), last: last});
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), mon_q[i].data, exp_q[i].data);
      check_eq($sformatf("%s_dut_id_last%0d", tag, i),
               {mon_q[i].d, mon_q[i].id, mon_q[i].last},
               {exp_q[i].d, exp_q[i].id, exp_q[i].last});
    end
    exp_q.delete();
  endtask

  // Send an n-beat frame on port p of instance d, data base, base+1, ...
  // Returns #1 after the edge that accepted the last beat.
  task automatic send_frame(input int d, input int p, input int n, input logic [7:0] base);
    int   waited;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      s_tdata[d][p*8 +: 8] = base + 8'(i);
      s_tlast[d][p]        = (i == n - 1);
      s_tvalid[d][p]       = 1'b1;
      rdy    = 1'b0;
      waited = 0;
      while (!rdy && waited < 200) begin
        @(negedge clk);
        rdy = s_tready[d][p];
        waited++;
      end
      if (!rdy) begin
        check_eq($sformatf("ready_timeout_d%0d_p%0d", d, p), {31'd0, rdy}, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid[d][p] = 1'b0;
    s_tlast[d][p]  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int k = 0; k < NumDut; k++) begin
      s_tdata[k]  = '0;
      s_tvalid[k] = '0;
      s_tlast[k]  = '0;
      m_tready[k] = 1'b1;
    end

    // Reset state
    #1 rst_n = 1'b0;
    idle_cycles(2);
    check_eq("rst_m_tvalid", m_tvalid[0], 1'b0);
    check_eq("rst_busy", busy[0], 1'b0);
    check_eq("rst_s_tready", s_tready[0], 4'h0);
    check_eq("rst_m_tdata", m_tdata[0], 8'h00);
    check_eq("rst_m_tid_last", {m_tid[0], m_tlast[0]}, 3'b000);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single frame on port 2, latency and busy timing
    mon_q.delete();
    c0 = cyc;
    fork
      send_frame(0, 2, 3, 8'hA1);
      begin
        @(negedge clk);
        check_eq("t1_busy_c0", busy[0], 1'b0);
        check_eq("t1_rdy_c0", s_tready[0][2], 1'b0);
        @(negedge clk);
        check_eq("t1_busy_c1", busy[0], 1'b1);
        check_eq("t1_rdy_c1", s_tready[0][2], 1'b1);
      end
    join
    check_eq("t1_busy_after_last", busy[0], 1'b0);
    idle_cycles(4);
    if (mon_q.size() == 3) begin
      check_eq("t1_first_latency", mon_q[0].cyc - 32'(c0), 32'd2);
      check_eq("t1_last_cycle", mon_q[2].cyc - 32'(c0), 32'd4);
    end
    exp_beat(0, 8'hA1, 2, 1'b0);
    exp_beat(0, 8'hA2, 2, 1'b0);
    exp_beat(0, 8'hA3, 2, 1'b1);
    check_seq("t1");

    // Priority, HIGH: port 1 first, one bubble, then port 3
    mon_q.delete();
    c0 = cyc;
    fork
      send_frame(0, 1, 2, 8'h10);
      send_frame(0, 3, 2, 8'h30);
    join
    idle_cycles(4);
    if (mon_q.size() == 4) begin
      check_eq("t2_bubble", mon_q[2].cyc - 32'(c0), 32'd5);
    end
    exp_beat(0, 8'h10, 1, 1'b0);
    exp_beat(0, 8'h11, 1, 1'b1);
    exp_beat(0, 8'h30, 3, 1'b0);
    exp_beat(0, 8'h31, 3, 1'b1);
    check_seq("t2_high");

    // Priority, LOW: port 3 first
    mon_q.delete();
    fork
      send_frame(1, 1, 2, 8'h10);
      send_frame(1, 3, 2, 8'h30);
    join
    idle_cycles(4);
    exp_beat(1, 8'h30, 3, 1'b0);
    exp_beat(1, 8'h31, 3, 1'b1);
    exp_beat(1, 8'h10, 1, 1'b0);
    exp_beat(1, 8'h11, 1, 1'b1);
    check_seq("t2_low");

    // Round robin, LOW: 3,1,0,3,1,0
    mon_q.delete();
    fork
      begin send_frame(2, 0, 1, 8'h00); send_frame(2, 0, 1, 8'h01); end
      begin send_frame(2, 1, 1, 8'h10); send_frame(2, 1, 1, 8'h11); end
      begin send_frame(2, 3, 1, 8'h30); send_frame(2, 3, 1, 8'h31); end
    join
    idle_cycles(4);
    exp_beat(2, 8'h30, 3, 1'b1);
    exp_beat(2, 8'h10, 1, 1'b1);
    exp_beat(2, 8'h00, 0, 1'b1);
    exp_beat(2, 8'h31, 3, 1'b1);
    exp_beat(2, 8'h11, 1, 1'b1);
    exp_beat(2, 8'h01, 0, 1'b1);
    check_seq("t3_rr_low");

    // Round robin, HIGH: 0,1,3,0,1,3
    mon_q.delete();
    fork
      begin send_frame(3, 0, 1, 8'h00); send_frame(3, 0, 1, 8'h01); end
      begin send_frame(3, 1, 1, 8'h10); send_frame(3, 1, 1, 8'h11); end
      begin send_frame(3, 3, 1, 8'h30); send_frame(3, 3, 1, 8'h31); end
    join
    idle_cycles(4);
    exp_beat(3, 8'h00, 0, 1'b1);
    exp_beat(3, 8'h10, 1, 1'b1);
    exp_beat(3, 8'h30, 3, 1'b1);
    exp_beat(3, 8'h01, 0, 1'b1);
    exp_beat(3, 8'h11, 1, 1'b1);
    exp_beat(3, 8'h31, 3, 1'b1);
    check_seq("t3_rr_high");

    // No preemption: port 0 requests while port 3 is mid-frame
    mon_q.delete();
    fork
      send_frame(0, 3, 4, 8'h40);
      begin
        idle_cycles(2);
        send_frame(0, 0, 1, 8'h0F);
      end
    join
    idle_cycles(4);
    exp_beat(0, 8'h40, 3, 1'b0);
    exp_beat(0, 8'h41, 3, 1'b0);
    exp_beat(0, 8'h42, 3, 1'b0);
    exp_beat(0, 8'h43, 3, 1'b1);
    exp_beat(0, 8'h0F, 0, 1'b1);
    check_seq("t4_nopreempt");

    // Backpressure: m_tready low for 5 cycles during a 6-beat frame
    mon_q.delete();
    fork
      send_frame(0, 1, 6, 8'h60);
      begin
        idle_cycles(2);
        m_tready[0] = 1'b0;
        @(negedge clk);
        check_eq("t5_rdy_skid_free", s_tready[0][1], 1'b1);
        check_eq("t5_out_valid", m_tvalid[0], 1'b1);
        check_eq("t5_out_data0", m_tdata[0], 8'h60);
        @(negedge clk);
        check_eq("t5_rdy_skid_full", s_tready[0][1], 1'b0);
        check_eq("t5_out_data1", m_tdata[0], 8'h60);
        repeat (3) @(negedge clk);
        check_eq("t5_rdy_still_low", s_tready[0][1], 1'b0);
        check_eq("t5_out_stable", {m_tvalid[0], m_tdata[0], m_tid[0], m_tlast[0]},
                 {1'b1, 8'h60, 2'd1, 1'b0});
        @(posedge clk);
        #1 m_tready[0] = 1'b1;
      end
    join
    idle_cycles(5);
    for (int i = 0; i < 6; i++) exp_beat(0, 8'h60 + 8'(i), 1, i == 5);
    check_seq("t5_backpressure");

    // Reset mid-frame; round-robin instance primed so its mask is non-empty
    mon_q.delete();
    send_frame(2, 3, 1, 8'h3F);
    idle_cycles(3);
    mon_q.delete();
    s_tdata[0][2*8 +: 8] = 8'h50;
    s_tlast[0][2]        = 1'b0;
    s_tvalid[0][2]       = 1'b1;
    idle_cycles(2);
    s_tdata[0][2*8 +: 8] = 8'h51;
    idle_cycles(1);
    s_tdata[0][2*8 +: 8] = 8'h52;
    check_eq("t6_pre_m_tvalid", m_tvalid[0], 1'b1);
    check_eq("t6_pre_busy", busy[0], 1'b1);
    check_eq("t6_pre_rdy", s_tready[0][2], 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_m_tvalid", m_tvalid[0], 1'b0);
    check_eq("t6_rst_busy", busy[0], 1'b0);
    check_eq("t6_rst_rdy", s_tready[0], 4'h0);
    s_tvalid[0][2] = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    exp_beat(0, 8'h50, 2, 1'b0);
    check_seq("t6_before_rst");

    mon_q.delete();
    send_frame(0, 2, 3, 8'h52);
    idle_cycles(4);
    exp_beat(0, 8'h52, 2, 1'b0);
    exp_beat(0, 8'h53, 2, 1'b0);
    exp_beat(0, 8'h54, 2, 1'b1);
    check_seq("t6_after_rst");

    // Mask cleared by reset: port 3 wins over port 1 again
    mon_q.delete();
    fork
      send_frame(2, 1, 1, 8'h1A);
      send_frame(2, 3, 1, 8'h3A);
    join
    idle_cycles(4);
    exp_beat(2, 8'h3A, 3, 1'b1);
    exp_beat(2, 8'h1A, 1, 1'b1);
    check_seq("t6_mask_cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_arb_mux.md
Name: axis_frame_arb_mux

Overview:
- Merges PORTS AXI-stream-style inputs onto one output stream.
- Arbitrates per frame: once a port is granted, the grant holds until that port's tlast beat is accepted. Frames are never interleaved.
- Sits in front of shared single-stream resources such as MAC TX, DMA write channels and FIFOs.
- Has an internal priority/round-robin arbiter and a registered output stage with skid buffer.

Parameters:
- PORTS, 4, number of input ports (>=2).
- DATA_WIDTH, 8, bits per beat.
- TYPE, "ROUND_ROBIN", "PRIORITY" or "ROUND_ROBIN".
- LSB_PRIORITY, "LOW", "LOW" means higher index wins; "HIGH" means port 0 wins.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  PORTS*DATA_WIDTH  input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  PORTS  per-port valid.
- s_tlast  in  PORTS  per-port end of frame.
- s_tready  out  PORTS  per-port ready.
- m_tdata  out  DATA_WIDTH  output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of frame.
- m_tid  out  $clog2(PORTS)  source port index of the current output beat.
- m_tready  in  1  downstream ready.
- busy  out  1  a frame is granted (grant active).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - grant inactive, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, busy=0.
  - Round-robin mask cleared, skid register empty.
- State machine:
  - IDLE: each cycle, if any s_tvalid is set, pick the winner per TYPE/LSB_PRIORITY. At the edge, register grant one-hot, grant index and busy=1, and go to ACTIVE.
  - ACTIVE: s_tready[g] = !skid_valid; all other s_tready bits = 0. A beat transfers when s_tvalid[g] && s_tready[g].
  - ACTIVE exit: when the transferred beat has s_tlast[g]=1, clear grant and busy at that edge and return to IDLE. The next arbitration happens in the following cycle, so there is exactly one cycle of arbitration bubble between frames.
- Arbitration:
  - PRIORITY: lowest index wins if LSB_PRIORITY="HIGH"; highest index wins if "LOW".
  - ROUND_ROBIN: after granting index k, the mask keeps only ports strictly lower in priority than k. The next grant goes to the highest-priority masked request; if the masked set is empty, it goes to the highest-priority unmasked request. The mask updates only on a grant.
- Preemption: none. Requests arriving during ACTIVE, even higher-priority ones, wait until after the tlast beat.
- Output stage: an output register plus a one-beat skid register.
  - Accepted beat loads the output register if it is empty or being drained (m_tready=1); otherwise it loads the skid register.
  - Skid contents move to the output register when it drains.
  - m_tid is registered alongside each beat.
- Latency and throughput:
  - s_tvalid rising in IDLE at cycle 0 -> s_tready high in cycle 1 -> first beat on m_tvalid in cycle 2.
  - Sustained 1 beat/cycle while m_tready=1.
- Backpressure:
  - With m_tready=0, at most 2 beats are buffered and s_tready[g] drops the cycle after the skid register fills.
  - No beat is lost or duplicated.
  - m_tdata, m_tlast and m_tid are stable while m_tvalid=1 && m_tready=0.
- Simultaneous events:
  - tlast accept and a new request in the same cycle: the new request is arbitrated in the next IDLE cycle.
  - Output drain and input accept in the same cycle: handled without a bubble.
- s_tvalid on the granted port dropping mid-frame: the grant is held and output simply idles.
- Reset mid-frame: all buffered beats are discarded and m_tvalid drops immediately. The upstream remainder of the frame is treated as a new frame after reset.
- busy stays 1 from the grant edge through the tlast accept edge.

Test Plan:
- Single frame, PORTS=4, TYPE=PRIORITY, LSB_PRIORITY=HIGH: port 2 sends 3 beats 0xA1,0xA2,0xA3 (last) with m_tready=1 -> m_tvalid first high 2 cycles after s_tvalid; beats appear in order, m_tid=2, m_tlast only on 0xA3; busy drops after the tlast accept.
- Priority: ports 1 and 3 request together -> port 1 frame first, then after one bubble cycle port 3; with LSB_PRIORITY=LOW, port 3 goes first.
- Round robin: ports 0, 1 and 3 continuously send 1-beat frames -> m_tid sequence in ROUND_ROBIN mode is 3,1,0,3,1,0 (LOW) or 0,1,3,0,1,3 (HIGH).
- No preemption: port 3 is mid-frame (4 beats) when port 0 requests with PRIORITY/HIGH -> all 4 port-3 beats are contiguous before any port-0 beat.
- Backpressure: m_tready=0 for 5 cycles during a 6-beat frame -> s_tready falls after 2 buffered beats; output data is stable; all 6 beats are delivered once, in order, after m_tready=1.
- Reset mid-frame: rst_n pulsed low after 2 of 5 beats -> m_tvalid, busy and s_tready go 0 immediately; after release, a new request is granted normally with the mask cleared.
